// File: rtl/audio_pkg.sv
// Shared audio definitions for the capture path.
//   rec_state_t    : recorder take states (IDLE, ARMED, RECORD, DONE)
//   SAMPLE_W       : codec sample width
//   SAMPLE_ADDR_W  : sample RAM address width
//   sample_t       : signed codec sample
package audio_pkg;

  localparam int SAMPLE_W      = 24;
  localparam int SAMPLE_ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    DONE   = 2'd3
  } rec_state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/stereo_mix_abs.sv
// Combinational stereo-to-mono mix plus saturated magnitude.
// Shared with the level meter, so it carries no state.
//   i_left, i_right : signed stereo samples
//   o_mono          : (left + right) >>> 1, exact (no overflow possible)
//   o_magnitude     : |o_mono|, the most negative value saturates to max positive
module stereo_mix_abs
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
) (
  input  logic signed [DATA_W-1:0] i_left,
  input  logic signed [DATA_W-1:0] i_right,
  output logic signed [DATA_W-1:0] o_mono,
  output logic        [DATA_W-2:0] o_magnitude
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_neg;

  // One guard bit keeps the sum exact; dropping bit 0 is the arithmetic shift.
  assign w_sum  = {i_left[DATA_W-1], i_left} + {i_right[DATA_W-1], i_right};
  assign o_mono = w_sum[DATA_W:1];

  // Negation only leaves the top bit set for the most negative input,
  // which is exactly the case that must saturate.
  assign w_neg = '0 - o_mono;
  assign o_magnitude = !o_mono[DATA_W-1] ? o_mono[DATA_W-2:0] :
                       w_neg[DATA_W-1]   ? {(DATA_W-1){1'b1}} :
                                           w_neg[DATA_W-2:0];

endmodule

// File: rtl/sample_recorder.sv
// Level-triggered sample recorder between the codec read side and a
// single-port sample RAM write port.
//   CLOCK_50, reset        : clock and synchronous active-high reset
//   arm / stop / abort     : single-cycle control pulses (abort > stop > arm)
//   threshold              : unsigned trigger magnitude
//   read_ready, readdata_* : codec ADC pair; read mirrors read_ready so the
//                            codec FIFO always drains
//   wr_en/wr_addr/wr_data  : RAM write port, one cycle after the sample event
//   length                 : writes issued in the current take (up to 2**ADDR_W)
//   busy / done            : ARMED-or-RECORD / DONE
module sample_recorder
  import audio_pkg::*;
#(
  parameter int ADDR_W = SAMPLE_ADDR_W,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     abort,
  input  logic        [DATA_W-2:0] threshold,
  input  logic                     read_ready,
  input  logic signed [DATA_W-1:0] readdata_left,
  input  logic signed [DATA_W-1:0] readdata_right,
  output logic                     read,
  output logic                     wr_en,
  output logic        [ADDR_W-1:0] wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic          [ADDR_W:0] length,
  output logic                     busy,
  output logic                     done
);

  rec_state_t                r_state;
  logic                      r_wr_en;
  logic        [ADDR_W-1:0]  r_wr_addr;
  logic signed [DATA_W-1:0]  r_wr_data;
  logic        [ADDR_W:0]    r_length;

  logic signed [DATA_W-1:0]  w_mono;
  logic        [DATA_W-2:0]  w_mag;
  logic                      w_trigger;
  logic                      w_last;

  stereo_mix_abs #(.DATA_W(DATA_W)) u_mix (
    .i_left      (readdata_left),
    .i_right     (readdata_right),
    .o_mono      (w_mono),
    .o_magnitude (w_mag)
  );

  assign read      = read_ready;
  assign w_trigger = read_ready && (w_mag >= threshold);
  // Inside RECORD the count never reaches 2**ADDR_W, so the low bits
  // all-ones means this event fills the final address.
  assign w_last    = (r_length[ADDR_W-1:0] == {ADDR_W{1'b1}});

  always_ff @(posedge CLOCK_50) begin
    // Strobe defaults low; launching a write re-asserts it for one cycle.
    r_wr_en <= 1'b0;
    if (reset) begin
      r_state   <= IDLE;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_length  <= '0;
    end else if (abort && (r_state != IDLE)) begin
      r_state  <= IDLE;
      r_length <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state  <= ARMED;
            r_length <= '0;
          end
        end
        ARMED: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_trigger) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_length[ADDR_W-1:0];
            r_wr_data <= w_mono;
            r_length  <= r_length + 1'b1;
            r_state   <= RECORD;
          end
        end
        RECORD: begin
          // A sample coincident with stop is still kept.
          if (read_ready) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_length[ADDR_W-1:0];
            r_wr_data <= w_mono;
            r_length  <= r_length + 1'b1;
          end
          if (stop || (read_ready && w_last)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (arm) begin
            r_state  <= ARMED;
            r_length <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign length  = r_length;
  assign busy    = (r_state == ARMED) || (r_state == RECORD);
  assign done    = (r_state == DONE);

endmodule
